// File: rtl/cnt_pkg.sv
// Shared types and next-state helpers for the modulo-N counter family.
package cnt_pkg;

    typedef enum logic {CNT_DOWN = 1'b0, CNT_UP = 1'b1} cnt_dir_t;

    // Next count plus a flag marking a genuine modulus wrap.
    typedef struct packed {
        logic [31:0] val;
        logic        wrp;
    } cnt_next_t;

    // Terminal value for the given direction, masked to the register width.
    function automatic logic [31:0] tc_val(input cnt_dir_t dir,
                                           input int unsigned modulus,
                                           input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (dir == CNT_UP) ? ((modulus - 32'd1) & mask) : 32'd0;
    endfunction

    // One counting step. Out-of-range states fold back into range without
    // being reported as a wrap, so ovf only records real modulus rollovers.
    function automatic cnt_next_t next_val(input logic [31:0] q,
                                           input cnt_dir_t dir,
                                           input int unsigned modulus);
        cnt_next_t r;
        r.wrp = 1'b0;
        if (dir == CNT_UP) begin
            if (q == modulus - 32'd1) begin
                r.val = 32'd0;
                r.wrp = 1'b1;
            end else if (q >= modulus) begin
                r.val = 32'd0;
            end else begin
                r.val = q + 32'd1;
            end
        end else begin
            if (q == 32'd0) begin
                r.val = modulus - 32'd1;
                r.wrp = 1'b1;
            end else if (q >= modulus) begin
                r.val = modulus - 32'd1;
            end else begin
                r.val = q - 32'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_counter_tc.sv
// Terminal-count / ripple-carry decode. rco ignores enp so a cascade of
// counters sees carry as soon as the lower stage sits at its terminal value.
module sync_counter_tc
    import cnt_pkg::*;
#(
    parameter int          WIDTH   = 4,
    parameter int unsigned MODULUS = 2**WIDTH
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic             ent,
    output logic            rco
);

    logic tc;

    // Out-of-range q can never equal 0 or MODULUS-1, so it never raises tc.
    always_comb begin
        tc  = (32'(q) == tc_val(cnt_dir_t'(up), MODULUS, WIDTH));
        rco = ent & tc;
    end

endmodule

// File: rtl/sync_counter_n.sv
// Parametrised 163-style synchronous counter with programmable modulus,
// up/down mode, sticky overflow and a registered wrap pulse.
module sync_counter_n
    import cnt_pkg::*;
#(
    parameter int          WIDTH   = 4,
    parameter int unsigned MODULUS = 2**WIDTH,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             enp,
    input  logic             ent,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             rco,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

    cnt_next_t        nx;
    logic [WIDTH-1:0] q_nx;
    logic             cnt_en;

    sync_counter_tc #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_tc (
        .q   (q),
        .up  (up),
        .ent (ent),
        .rco (rco)
    );

    // Candidate next count for this edge's direction.
    always_comb begin
        cnt_en = enp & ent;
        nx     = next_val(32'(q), cnt_dir_t'(up), MODULUS);
        q_nx   = WIDTH'(nx.val);
    end

    // Priority: rst > clr > load > count > hold; wrap is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q    <= RST_Q;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else if (load) begin
            q    <= din;
            wrap <= 1'b0;
        end else if (cnt_en) begin
            q    <= q_nx;
            wrap <= nx.wrp;
            if (nx.wrp)
                ovf <= 1'b1;
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_counter_n.sv
// Randomised check of sync_counter_n: a MODULUS=10 instance and a two-stage
// MODULUS=16 cascade, both compared every cycle against arithmetic models.
module tb_sync_counter_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // MODULUS=10 instance
    logic       a_rst, a_clr, a_load, a_enp, a_ent, a_up;
    logic [3:0] a_din, a_q;
    logic       a_rco, a_wrap, a_ovf;

    // cascade (low.rco -> high.ent)
    logic       c_rst, c_enp, c_ent;
    logic [3:0] lo_q, hi_q;
    logic       lo_rco, lo_wrap, lo_ovf, hi_rco, hi_wrap, hi_ovf;

    sync_counter_n #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) u_a (
        .clk(clk), .rst(a_rst), .clr(a_clr), .load(a_load), .din(a_din),
        .enp(a_enp), .ent(a_ent), .up(a_up),
        .q(a_q), .rco(a_rco), .wrap(a_wrap), .ovf(a_ovf)
    );

    sync_counter_n #(.WIDTH(4)) u_lo (
        .clk(clk), .rst(c_rst), .clr(1'b0), .load(1'b0), .din(4'd0),
        .enp(c_enp), .ent(c_ent), .up(1'b1),
        .q(lo_q), .rco(lo_rco), .wrap(lo_wrap), .ovf(lo_ovf)
    );

    sync_counter_n #(.WIDTH(4)) u_hi (
        .clk(clk), .rst(c_rst), .clr(1'b0), .load(1'b0), .din(4'd0),
        .enp(c_enp), .ent(lo_rco), .up(1'b1),
        .q(hi_q), .rco(hi_rco), .wrap(hi_wrap), .ovf(hi_ovf)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Models: A is an integer in 0..15 with modulus 10; cascade is one
    // integer 0..255 whose nibbles are the two stages.
    int mq = 0;  bit mw = 0, mo = 0;
    int mc = 0;  bit mlw = 0, mlo = 0, mhw = 0, mho = 0;

    always @(posedge clk) begin
        if (a_rst || a_clr) begin
            mq = 0; mw = 0; mo = 0;
        end else if (a_load) begin
            mq = a_din; mw = 0;
        end else if (a_enp && a_ent) begin
            mw = 0;
            if (a_up) begin
                if (mq == 9)     begin mq = 0; mw = 1; mo = 1; end
                else if (mq > 9) mq = 0;
                else             mq = mq + 1;
            end else begin
                if (mq == 0)     begin mq = 9; mw = 1; mo = 1; end
                else if (mq > 9) mq = 9;
                else             mq = mq - 1;
            end
        end else begin
            mw = 0;
        end

        if (c_rst) begin
            mc = 0; mlw = 0; mlo = 0; mhw = 0; mho = 0;
        end else if (c_enp && c_ent) begin
            mlw = (mc % 16 == 15);
            mhw = (mc == 255);
            mlo = mlo | mlw;
            mho = mho | mhw;
            mc  = (mc + 1) % 256;
        end else begin
            mlw = 0; mhw = 0;
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_q",     a_q,     mq);
            chk("a_rco",   a_rco,   int'(a_ent && ((a_up && mq == 9) || (!a_up && mq == 0))));
            chk("a_wrap",  a_wrap,  mw);
            chk("a_ovf",   a_ovf,   mo);
            chk("lo_q",    lo_q,    mc % 16);
            chk("hi_q",    hi_q,    mc / 16);
            chk("lo_rco",  lo_rco,  int'(c_ent && (mc % 16 == 15)));
            chk("hi_rco",  hi_rco,  int'(c_ent && (mc == 255)));
            chk("lo_wrap", lo_wrap, mlw);
            chk("lo_ovf",  lo_ovf,  mlo);
            chk("hi_wrap", hi_wrap, mhw);
            chk("hi_ovf",  hi_ovf,  mho);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        a_rst = 1; a_clr = 0; a_load = 0; a_din = 0; a_enp = 0; a_ent = 0; a_up = 1;
        c_rst = 1; c_enp = 0; c_ent = 0;
        tick();
        chk_on = 1;
        tick();
        chk("rst_a_q", a_q, 0);
        chk("rst_a_ovf", a_ovf, 0);
        chk("rst_lo_q", lo_q, 0);

        // cascade from reset: 0..255 -> 0
        a_rst = 0; c_rst = 0; c_enp = 1; c_ent = 1;
        repeat (15) tick();
        chk("c15_lo_q", lo_q, 15);
        chk("c15_lo_rco", lo_rco, 1);
        tick();
        chk("c16_lo_q", lo_q, 0);
        chk("c16_lo_wrap", lo_wrap, 1);
        chk("c16_lo_ovf", lo_ovf, 1);
        chk("c16_hi_q", hi_q, 1);
        tick();
        chk("c17_lo_wrap", lo_wrap, 0);
        chk("c17_lo_ovf", lo_ovf, 1);
        repeat (238) tick();
        chk("c255_hi_q", hi_q, 15);
        chk("c255_lo_q", lo_q, 15);
        chk("c255_hi_rco", hi_rco, 1);
        tick();
        chk("c256_hi_q", hi_q, 0);
        chk("c256_lo_q", lo_q, 0);
        chk("c256_hi_wrap", hi_wrap, 1);
        chk("c256_hi_ovf", hi_ovf, 1);

        // down count through zero with modulus 10
        a_load = 1; a_din = 2; a_up = 0;
        tick();
        chk("ld2_q", a_q, 2);
        a_load = 0; a_enp = 1; a_ent = 1;
        tick(); chk("dn_q1", a_q, 1);
        tick(); chk("dn_q0", a_q, 0); chk("dn_rco0", a_rco, 1);
        tick(); chk("dn_q9", a_q, 9); chk("dn_wrap", a_wrap, 1); chk("dn_ovf", a_ovf, 1);
        tick(); chk("dn_q8", a_q, 8); chk("dn_wrap_off", a_wrap, 0);

        // out-of-range load, then up and down recovery
        a_load = 1; a_din = 12;
        tick(); chk("oor_q", a_q, 12); chk("oor_ovf", a_ovf, 1);
        a_load = 0; a_up = 1; #1;
        chk("oor_rco", a_rco, 0);
        tick(); chk("oor_up_q", a_q, 0); chk("oor_up_wrap", a_wrap, 0);
        a_load = 1; a_din = 12;
        tick();
        a_load = 0; a_up = 0;
        tick(); chk("oor_dn_q", a_q, 9); chk("oor_dn_wrap", a_wrap, 0);

        // priority: clr over load over count
        a_clr = 1; a_load = 1; a_din = 5;
        tick(); chk("clr_q", a_q, 0); chk("clr_ovf", a_ovf, 0);
        a_clr = 0;
        tick(); chk("ld_q5", a_q, 5);
        a_load = 0; a_enp = 0;
        tick(); chk("hold_q5", a_q, 5);

        // enable gating at terminal count
        a_load = 1; a_din = 9;
        tick();
        a_load = 0; a_up = 1; a_enp = 0; a_ent = 1; #1;
        chk("gate_rco", a_rco, 1);
        tick(); chk("gate_q", a_q, 9);
        a_ent = 0; #1;
        chk("gate_rco_ent0", a_rco, 0);

        // reset mid-count after an overflow
        a_enp = 1; a_ent = 1;
        tick(); chk("pre_q", a_q, 0); chk("pre_ovf", a_ovf, 1);
        a_load = 1; a_din = 7;
        tick(); chk("ld7_q", a_q, 7);
        a_load = 0; a_rst = 1;
        tick(); chk("mrst_q", a_q, 0); chk("mrst_wrap", a_wrap, 0); chk("mrst_ovf", a_ovf, 0);
        a_rst = 0;

        // randomised traffic
        repeat (800) begin
            a_rst  = ($urandom % 64) == 0;
            a_clr  = ($urandom % 16) == 0;
            a_load = ($urandom % 8) == 0;
            a_din  = 4'($urandom);
            a_enp  = ($urandom % 4) != 0;
            a_ent  = ($urandom % 4) != 0;
            a_up   = 1'($urandom);
            c_rst  = ($urandom % 128) == 0;
            c_enp  = ($urandom % 8) != 0;
            c_ent  = ($urandom % 8) != 0;
            tick();
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
